// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD word generator and its checker.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int WORD_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [WORD_W-1:0] BCD_MAX = 16'h9999;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit of a ripple BCD adder: binary add, then fold 10..19 back
// into 0..9 with a carry out.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  // Binary digit sum with decimal correction.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (raw > 5'd9) begin
      s    = 4'(raw - 5'd10);
      cout = 1'b1;
    end else begin
      s    = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_mult11_gen.sv
// Packed-BCD word source: starts at a seed and steps by STEP after every
// accepted word, under a valid/ready handshake.
module bcd_mult11_gen
  import bcd_pkg::*;
#(
  parameter logic [15:0] STEP = 16'h0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [9:0]  count,
  input  logic        ready,
  output logic        valid,
  output logic [15:0] D,
  output logic        last,
  output logic        busy,
  output logic        err
);

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  remaining;
  logic [15:0] d_step;
  logic        c1, c2, c3;
  logic        carry_out_unused;
  logic        seed_ok;
  logic        xfer;

  // True when every nibble of w is a decimal digit.
  function automatic logic bcd_word_ok(input logic [WORD_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign seed_ok = bcd_word_ok(seed);
  assign xfer    = valid && ready;

  // D + STEP, digit by digit; the thousands carry is dropped so the word
  // wraps modulo 10000.
  bcd_digit_add u_dig0 (.a(D[3:0]),   .b(STEP[3:0]),   .cin(1'b0), .s(d_step[3:0]),   .cout(c1));
  bcd_digit_add u_dig1 (.a(D[7:4]),   .b(STEP[7:4]),   .cin(c1),   .s(d_step[7:4]),   .cout(c2));
  bcd_digit_add u_dig2 (.a(D[11:8]),  .b(STEP[11:8]),  .cin(c2),   .s(d_step[11:8]),  .cout(c3));
  bcd_digit_add u_dig3 (.a(D[15:12]), .b(STEP[15:12]), .cin(c3),   .s(d_step[15:12]), .cout(carry_out_unused));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a good seed with a non-zero count starts a run; the final
  // accepted word ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && seed_ok && (count != 10'd0)) state_nxt = RUN;
      RUN:  if (xfer && (remaining == 10'd1))          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word, remaining count, valid and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      D         <= 16'h0000;
      remaining <= 10'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!seed_ok) begin
              err <= 1'b1;
            end else if (count == 10'd0) begin
              err <= 1'b0;
            end else begin
              err       <= 1'b0;
              D         <= seed;
              remaining <= count;
              valid     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (remaining == 10'd1) begin
              valid     <= 1'b0;
              remaining <= 10'd0;
            end else begin
              D         <= d_step;
              remaining <= remaining - 10'd1;
            end
          end
        end
        default: valid <= 1'b0;
      endcase
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    last = valid && (remaining == 10'd1);
    busy = (state == RUN);
  end

endmodule
